// File: rtl/keyboard_pkg.sv
// Shared definitions for the note keyboard: key count, ASCII code table and
// the per-button debounce state encoding.
package keyboard_pkg;

   localparam int NUM_KEYS = 12;

   localparam logic [7:0] KEY_NONE = 8'h00;

   // Semitone C..B mapped onto the PC keyboard's bottom row; LED/tone decoders use the same table.
   localparam logic [7:0] KEY_ASCII [0:NUM_KEYS-1] = '{
      8'h7A, 8'h73, 8'h78, 8'h64, 8'h63, 8'h76,
      8'h67, 8'h62, 8'h68, 8'h6E, 8'h6A, 8'h6D
   };

   typedef enum logic [1:0] {
      DB_REL        = 2'd0,
      DB_PRESS_PEND = 2'd1,
      DB_PRESSED    = 2'd2,
      DB_REL_PEND   = 2'd3
   } db_state_t;

   // Lowest pressed index wins; scanning downward lets the last hit be the winner.
   function automatic logic [7:0] key_encode(input logic [NUM_KEYS-1:0] keys);
      logic [7:0] code;
      code = KEY_NONE;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) code = KEY_ASCII[i];
      end
      return code;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: synchroniser, four-state debounce FSM and its stability counter.
//
//  state         | meaning
//  DB_REL        | accepted released, waiting for synced press
//  DB_PRESS_PEND | press seen, counting stable-high cycles
//  DB_PRESSED    | accepted pressed, waiting for synced release
//  DB_REL_PEND   | release seen, counting stable-low cycles
module key_debounce
   import keyboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic i_btn,
   output logic o_pressed
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   db_state_t              r_state;
   logic                   r_pressed;
   logic                   w_s;

   assign w_s       = r_sync[SYNC_STAGES-1];
   assign o_pressed = r_pressed;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      end
   end

   // Counter is cleared on every pending entry, so it never needs to wrap.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state   <= DB_REL;
         r_cnt     <= '0;
         r_pressed <= 1'b0;
      end else begin
         case (r_state)
            DB_REL: begin
               if (w_s) begin
                  r_state <= DB_PRESS_PEND;
                  r_cnt   <= '0;
               end
            end
            DB_PRESS_PEND: begin
               if (!w_s) begin
                  r_state <= DB_REL;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= DB_PRESSED;
                  r_pressed <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DB_PRESSED: begin
               if (!w_s) begin
                  r_state <= DB_REL_PEND;
                  r_cnt   <= '0;
               end
            end
            DB_REL_PEND: begin
               if (w_s) begin
                  r_state <= DB_PRESSED;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= DB_REL;
                  r_pressed <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= DB_REL;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_scan_encoder.sv
// Debounces the 12 note buttons and drives the shared 8-bit ASCII key-code bus
// with a one-cycle strobe whenever a new note code appears.
module key_scan_encoder
   import keyboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic [NUM_KEYS-1:0] inBtn,
   output logic [7:0]          outKey,
   output logic                outStrobe,
   output logic [NUM_KEYS-1:0] outPressed
);

   logic [NUM_KEYS-1:0] w_pressed;
   logic [7:0]          w_code;
   logic [7:0]          r_key;
   logic                r_strobe;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_db (
         .clk       (clk),
         .rstb      (rstb),
         .i_btn     (inBtn[g]),
         .o_pressed (w_pressed[g])
      );
   end

   assign w_code = key_encode(w_pressed);

   // Strobe only on a change to a real note; dropping back to KEY_NONE is silent.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_key    <= KEY_NONE;
         r_strobe <= 1'b0;
      end else begin
         r_key    <= w_code;
         r_strobe <= (w_code != r_key) && (w_code != KEY_NONE);
      end
   end

   assign outKey     = r_key;
   assign outStrobe  = r_strobe;
   assign outPressed = w_pressed;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed bench for key_scan_encoder with DEBOUNCE_CYCLES=16, SYNC_STAGES=2.
module tb_key_scan_encoder;

   localparam int DB  = 16;
   localparam int SS  = 2;
   localparam int LAT = SS + DB + 2;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [11:0] inBtn = '0;
   logic [7:0]  outKey;
   logic        outStrobe;
   logic [11:0] outPressed;

   int          n_chk = 0;
   int          n_bad = 0;
   int          strobes;
   logic [11:0] press_seen;
   logic [7:0]  key_seen;
   int          cyc;

   key_scan_encoder #(
      .DEBOUNCE_CYCLES (DB),
      .SYNC_STAGES     (SS)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .inBtn      (inBtn),
      .outKey     (outKey),
      .outStrobe  (outStrobe),
      .outPressed (outPressed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         if (outStrobe) strobes++;
         press_seen |= outPressed;
         key_seen   |= outKey;
      end
   endtask

   // Cycles counted from the negedge where the stimulus was applied; max+1 on timeout.
   task automatic wait_key(input logic [7:0] exp, input int max, output int c);
      bit found;
      found = 0;
      c = 0;
      for (int i = 0; i < max && !found; i++) begin
         @(negedge clk);
         c++;
         if (outStrobe) strobes++;
         if (outKey == exp) found = 1;
      end
      if (!found) c = max + 1;
   endtask

   task automatic clear_marks();
      strobes    = 0;
      press_seen = '0;
      key_seen   = '0;
   endtask

   initial begin
      // 1: reset with every button held
      clear_marks();
      inBtn = 12'hFFF;
      rstb  = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_key", outKey, 8'h00);
      check("rst_strobe", outStrobe, 1'b0);
      check("rst_pressed", outPressed, 12'h000);
      rstb = 1'b1;
      wait_key(8'h7A, 60, cyc);
      check("rst_rel_lat", cyc, LAT);
      check("rst_rel_strobes", strobes, 1);
      check("rst_rel_pressed", outPressed, 12'hFFF);
      inBtn = 12'h000;
      wait_key(8'h00, 60, cyc);
      check("all_rel_lat", cyc, LAT);
      step(3);

      // 2: short glitch on bit 4
      clear_marks();
      inBtn[4] = 1'b1;
      step(10);
      inBtn[4] = 1'b0;
      step(30);
      check("glitch_pressed", press_seen, 12'h000);
      check("glitch_key", key_seen, 8'h00);
      check("glitch_strobes", strobes, 0);

      // 3: single key
      clear_marks();
      inBtn[9] = 1'b1;
      wait_key(8'h6E, 60, cyc);
      check("single_lat", cyc, LAT);
      step(5);
      check("single_strobes", strobes, 1);
      check("single_pressed", outPressed, 12'h200);
      clear_marks();
      inBtn[9] = 1'b0;
      wait_key(8'h00, 60, cyc);
      check("single_rel_lat", cyc, LAT);
      step(3);
      check("single_rel_strobes", strobes, 0);

      // 4: priority between bits 11 and 3
      clear_marks();
      inBtn[11] = 1'b1;
      inBtn[3]  = 1'b1;
      wait_key(8'h64, 60, cyc);
      check("prio_lat", cyc, LAT);
      step(3);
      check("prio_strobes", strobes, 1);
      clear_marks();
      inBtn[3] = 1'b0;
      wait_key(8'h6D, 60, cyc);
      check("prio_switch_lat", cyc, LAT);
      step(3);
      check("prio_switch_strobes", strobes, 1);
      clear_marks();
      inBtn[11] = 1'b0;
      wait_key(8'h00, 60, cyc);
      check("prio_rel_lat", cyc, LAT);
      step(3);
      check("prio_rel_strobes", strobes, 0);

      // 5: bounce on bit 0, then settle high
      clear_marks();
      for (int i = 0; i < 8; i++) begin
         inBtn[0] = ~inBtn[0];
         step(5);
      end
      check("bounce_pressed", press_seen, 12'h000);
      inBtn[0] = 1'b1;
      wait_key(8'h7A, 60, cyc);
      check("bounce_lat", cyc, LAT);
      step(3);
      check("bounce_strobes", strobes, 1);
      inBtn[0] = 1'b0;
      wait_key(8'h00, 60, cyc);
      step(3);

      // 6: async reset while bit 5 is mid-count and bit 7 is already accepted
      inBtn[7] = 1'b1;
      wait_key(8'h62, 60, cyc);
      check("pre_rst_key", outKey, 8'h62);
      inBtn[5] = 1'b1;
      step(11);
      check("pre_rst_key_hold", outKey, 8'h62);
      #1 rstb = 1'b0;
      #1;
      check("midrst_key", outKey, 8'h00);
      check("midrst_pressed", outPressed, 12'h000);
      check("midrst_strobe", outStrobe, 1'b0);
      @(negedge clk);
      clear_marks();
      rstb = 1'b1;
      wait_key(8'h76, 60, cyc);
      check("midrst_rel_lat", cyc, LAT);
      check("midrst_rel_strobes", strobes, 1);
      check("midrst_rel_pressed", outPressed, 12'h0A0);
      inBtn = '0;
      step(30);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
